// File: rtl/mul_acc_stage.sv
// mul_acc_stage: registered accumulate stage behind the combinational multiplier.
// Sums a stream of signed products into a guarded accumulator. On the beat
// flagged last it loads the vector sum, term count and a sticky overflow flag
// into a valid/ready output register.
// Build option: define SATURATE_EN to clamp each overflowing add instead of
// letting it wrap modulo 2^ACC_LEN.
module mul_acc_stage #(
    parameter int LEN     = 16,
    parameter int GUARD   = 4,
    parameter int CNT_LEN = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [2*LEN-1:0]          in_prod,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [2*LEN+GUARD-1:0]    out_sum,
    output logic        [CNT_LEN-1:0]        out_count,
    output logic                             out_ovf
);

    localparam int ACC_LEN = 2*LEN + GUARD;
    localparam logic [CNT_LEN-1:0] CNT_ONE = CNT_LEN'(1);

    typedef enum logic {ACCUM = 1'b0} state_t;

    // Overflowing result is replaced by the extreme value of matching sign.
    function automatic logic signed [ACC_LEN-1:0] sat_clamp(
        input logic signed [ACC_LEN-1:0] raw,
        input logic                      ovf,
        input logic                      neg
    );
        logic signed [ACC_LEN-1:0] res;
        res = raw;
        if (ovf) begin
            if (neg) res = {1'b1, {(ACC_LEN-1){1'b0}}};
            else     res = {1'b0, {(ACC_LEN-1){1'b1}}};
        end
        return res;
    endfunction

    state_t                    state_p0;
    state_t                    state_next;
    logic signed [ACC_LEN-1:0] acc_p0;
    logic        [CNT_LEN-1:0] cnt_p0;
    logic                      ovf_p0;

    logic signed [ACC_LEN-1:0] prod_ext;
    logic signed [ACC_LEN-1:0] sum_raw;
    logic signed [ACC_LEN-1:0] sum_next;
    logic                      add_ovf;
    logic        [CNT_LEN-1:0] cnt_inc;
    logic                      accept;

    // ---- stage 0: combinational add of the incoming product ----
    assign prod_ext = ACC_LEN'(in_prod);
    assign sum_raw  = acc_p0 + prod_ext;
    // Same-sign operands producing an opposite-sign result is a signed overflow.
    assign add_ovf  = (acc_p0[ACC_LEN-1] == prod_ext[ACC_LEN-1]) &&
                      (sum_raw[ACC_LEN-1] != acc_p0[ACC_LEN-1]);
`ifdef SATURATE_EN
    assign sum_next = sat_clamp(sum_raw, add_ovf, prod_ext[ACC_LEN-1]);
`else
    assign sum_next = sum_raw;
`endif
    assign cnt_inc  = cnt_p0 + CNT_ONE;

    // Ready depends only on the output register, never on in_valid.
    assign in_ready = (state_p0 == ACCUM) && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state logic: a single accumulate state, stalls are expressed via in_ready.
    always_comb begin
        state_next = ACCUM;
        case (state_p0)
            ACCUM:   state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_p0 <= ACCUM;
        else     state_p0 <= state_next;
    end

    // ---- stage 1: accumulator and output register update ----
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p0    <= '0;
            cnt_p0    <= '0;
            ovf_p0    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            // A consumed result frees the register; a same-edge last beat overrides.
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    out_sum   <= sum_next;
                    out_count <= cnt_inc;
                    out_ovf   <= ovf_p0 | add_ovf;
                    out_valid <= 1'b1;
                    acc_p0    <= '0;
                    cnt_p0    <= '0;
                    ovf_p0    <= 1'b0;
                end else begin
                    acc_p0    <= sum_next;
                    cnt_p0    <= cnt_inc;
                    ovf_p0    <= ovf_p0 | add_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_acc_stage.sv
// tb_mul_acc_stage: directed and scoreboard checks for mul_acc_stage.
// Instance a uses LEN=16/GUARD=4 (36-bit sum); instance b uses GUARD=0 (32-bit sum).
module tb_mul_acc_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance a signals
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_prod  = '0;
    logic               in_last  = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [35:0] out_sum;
    logic        [7:0]  out_count;
    logic               out_ovf;

    // Instance b signals
    logic               b_in_valid = 1'b0;
    logic               b_in_ready;
    logic signed [31:0] b_in_prod  = '0;
    logic               b_in_last  = 1'b0;
    logic               b_out_valid;
    logic               b_out_ready = 1'b1;
    logic        [31:0] b_out_sum;
    logic        [7:0]  b_out_count;
    logic               b_out_ovf;

    mul_acc_stage #(.LEN(16), .GUARD(4), .CNT_LEN(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    mul_acc_stage #(.LEN(16), .GUARD(0), .CNT_LEN(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat to instance a and hold it until accepted.
    task automatic send_a(input logic signed [31:0] p, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("send_a_timeout", 64'(n), 64'(0));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic signed [31:0] prod_q[$];
    logic               last_q[$];
    longint             exp_sum_q[$];
    int                 exp_cnt_q[$];

    initial begin
        longint vsum;
        int     vlen;
        int     idx;
        int     consumed;
        int     cyc;
        logic   acc_now;

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum",   out_sum,        64'(0));
        chk("rst_out_count", 64'(out_count), 64'(0));
        chk("rst_out_ovf",   64'(out_ovf),   64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));

        // 3, -5, 10(last) -> 8, count 3
        out_ready = 1'b1;
        send_a(3, 1'b0);
        send_a(-5, 1'b0);
        send_a(10, 1'b1);
        chk("v1_valid", 64'(out_valid), 64'(1));
        chk("v1_sum",   out_sum,        64'(8));
        chk("v1_count", 64'(out_count), 64'(3));
        chk("v1_ovf",   64'(out_ovf),   64'(0));
        tick();
        chk("v1_consumed", 64'(out_valid), 64'(0));
        send_a(4, 1'b1);
        chk("v2_sum_from_zero", out_sum,        64'(4));
        chk("v2_count",         64'(out_count), 64'(1));
        tick();

        // Single large negative beat, sign-extended to 36 bits
        send_a(-32'sd1073741824, 1'b1);
        chk("neg_sum",   out_sum,        -64'sd1073741824);
        chk("neg_count", 64'(out_count), 64'(1));
        tick();

        // Backpressure
        out_ready = 1'b0;
        send_a(7, 1'b1);
        chk("bp_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b1;
        in_prod  = 2;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_sum_held", out_sum,       64'(7));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(1));
        tick();
        chk("bp_consumed", 64'(out_valid), 64'(0));
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_valid2", 64'(out_valid), 64'(1));
        chk("bp_sum2",   out_sum,        64'(4));
        chk("bp_count2", 64'(out_count), 64'(2));
        tick();

        // Back-to-back last beats while consuming
        send_a(5, 1'b1);
        chk("b2b_sum1", out_sum, 64'(5));
        send_a(6, 1'b1);
        chk("b2b_valid", 64'(out_valid), 64'(1));
        chk("b2b_sum2",  out_sum,        64'(6));
        chk("b2b_count", 64'(out_count), 64'(1));
        tick();

        // GUARD=0 overflow on instance b
        b_in_valid = 1'b1;
        b_in_prod  = 32'sh40000000;
        b_in_last  = 1'b0;
        tick();
        b_in_last  = 1'b1;
        tick();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        chk("g0_valid", 64'(b_out_valid), 64'(1));
`ifdef SATURATE_EN
        chk("g0_sum", 64'(b_out_sum), 64'h7FFFFFFF);
`else
        chk("g0_sum", 64'(b_out_sum), 64'h80000000);
`endif
        chk("g0_ovf",   64'(b_out_ovf),   64'(1));
        chk("g0_count", 64'(b_out_count), 64'(2));
        tick();

        // 100 random vectors with random stalls on both sides
        for (int v = 0; v < 100; v++) begin
            vlen = $urandom_range(1, 4);
            vsum = 0;
            for (int k = 0; k < vlen; k++) begin
                logic signed [31:0] p;
                p = $urandom;
                prod_q.push_back(p);
                last_q.push_back(k == vlen - 1);
                vsum += longint'(p);
            end
            exp_sum_q.push_back(vsum);
            exp_cnt_q.push_back(vlen);
        end
        idx = 0;
        consumed = 0;
        cyc = 0;
        while (consumed < 100 && cyc < 5000) begin
            in_valid  = (idx < prod_q.size()) && ($urandom_range(0, 3) != 0);
            in_prod   = (idx < prod_q.size()) ? prod_q[idx] : '0;
            in_last   = (idx < prod_q.size()) ? last_q[idx] : 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid && !out_ready)
                chk("rnd_stall_ready", 64'(in_ready), 64'(0));
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (exp_sum_q.size() > 0) begin
                    chk("rnd_sum",   out_sum,        64'(exp_sum_q[0]));
                    chk("rnd_count", 64'(out_count), 64'(exp_cnt_q[0]));
                    chk("rnd_ovf",   64'(out_ovf),   64'(0));
                    void'(exp_sum_q.pop_front());
                    void'(exp_cnt_q.pop_front());
                end else begin
                    chk("rnd_extra_result", 64'(out_valid), 64'(0));
                end
                consumed++;
            end
            if (acc_now) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        chk("rnd_consumed", 64'(consumed), 64'(100));
        chk("rnd_all_beats", 64'(idx), 64'(prod_q.size()));
        tick();

        // Reset mid-vector
        send_a(5, 1'b0);
        send_a(6, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", 64'(out_valid), 64'(0));
        chk("mr_sum",   out_sum,        64'(0));
        chk("mr_count", 64'(out_count), 64'(0));
        chk("mr_ovf",   64'(out_ovf),   64'(0));
        send_a(9, 1'b1);
        chk("mr_sum9",   out_sum,        64'(9));
        chk("mr_count9", 64'(out_count), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
